// File: rtl/counter_pkg.sv
// Shared types, helpers and elaboration-time parameter checks for mod_counter_capture.
//   dir_e        : counting direction (maps directly onto the up_dn pin)
//   ptr_width()  : pointer/counter width helper that never returns 0
//   CP_CHECK_*   : generate-level guards placed inside module bodies
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // $clog2 that stays at least 1 bit wide, so depth/period 1 still gets a vector.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// MODULO must fit the counter width and give a real range.
`define CP_CHECK_MODULO(W_, M_) \
  if (((M_) < 2) || ((M_) > (1 << (W_)))) begin : g_bad_modulo \
    $error("mod_counter_capture: MODULO out of range for WIDTH"); \
  end

// FIFO depth must be a power of two with at least two entries.
`define CP_CHECK_DEPTH(D_) \
  if (((D_) < 2) || ((((D_) - 1) & (D_)) != 0)) begin : g_bad_depth \
    $error("capture_fifo: DEPTH must be a power of two >= 2"); \
  end

// File: rtl/capture_fifo.sv
// First-word-fall-through capture FIFO with sticky overflow flag.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (contents discarded)
//   push       : write push_data this edge (dropped if full without pop)
//   push_data  : value to store
//   pop        : consumer accepts head (ignored while empty)
//   head       : oldest entry, meaningful while valid
//   valid      : FIFO not empty
//   full       : occupancy == DEPTH
//   overflow   : sticky, set when a push was dropped
module capture_fifo
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full,
  output logic             overflow
);

  `CP_CHECK_DEPTH(DEPTH)

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             pop_ok_c, push_ok_c;

  // Pointer, occupancy and flag next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    ovf_d     = ovf_q;
    pop_ok_c  = pop & valid_q;
    // A full FIFO still accepts a push when the same edge frees a slot.
    push_ok_c = push & (~full_q | pop_ok_c);

    if (push_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push_ok_c, pop_ok_c})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (push & ~push_ok_c) ovf_d = 1'b1;

    valid_d = (occ_d != '0);
    full_d  = (occ_d == OCC_W'(DEPTH));
  end

  // Control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; no reset needed since valid gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= push_data;
  end

  assign head     = mem_q[rd_ptr_q];
  assign valid    = valid_q;
  assign full     = full_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/mod_counter_capture.sv
// Up/down modulo-N counter with load, terminal-count pulse, clock-enable
// divider tick and a save-edge capture FIFO for a valid/ready consumer.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   en, up_dn        : count enable and direction (1 = up)
//   load, load_val   : synchronous load (clamped to MODULO-1), wins over en
//   save             : capture request level; rising edge pushes current count
//   counter, tc      : current count, one-cycle pulse after an en-driven wrap
//   cap_data/valid   : FIFO head / not-empty
//   cap_ready        : consumer accepts head
//   cap_full         : FIFO holds DEPTH entries
//   cap_overflow     : sticky, a capture was dropped
//   div_tick         : one-cycle pulse every DIV cycles
module mod_counter_capture
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned MODULO = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DIV    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             save,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic [WIDTH-1:0] cap_data,
  output logic             cap_valid,
  input  logic             cap_ready,
  output logic             cap_full,
  output logic             cap_overflow,
  output logic             div_tick
);

  `CP_CHECK_MODULO(WIDTH, MODULO)

  if (DIV < 1) begin : g_bad_div
    $error("mod_counter_capture: DIV must be >= 1");
  end

  localparam int unsigned DIV_W = ptr_width(DIV);
  // One extra bit so MODULO == 2**WIDTH is representable in the clamp compare.
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULO - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             save_q, save_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             div_tick_q, div_tick_d;
  logic             push_c;
  dir_e             dir_c;

  // Counter, terminal count, save edge detect and divider next-state.
  always_comb begin
    cnt_d      = cnt_q;
    tc_d       = 1'b0;
    save_d     = save;
    div_cnt_d  = div_cnt_q + DIV_W'(1);
    div_tick_d = 1'b0;
    dir_c      = dir_e'(up_dn);

    if (load) begin
      cnt_d = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
    end else if (en) begin
      if (dir_c == DIR_UP) begin
        if (cnt_q == MAX_VAL) begin
          cnt_d = '0;
          tc_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d = MAX_VAL;
          tc_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end

    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d  = '0;
      div_tick_d = 1'b1;
    end

    push_c = save & ~save_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      tc_q       <= 1'b0;
      save_q     <= 1'b0;
      div_cnt_q  <= '0;
      div_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      tc_q       <= tc_d;
      save_q     <= save_d;
      div_cnt_q  <= div_cnt_d;
      div_tick_q <= div_tick_d;
    end
  end

  // Snapshot is the pre-update count, i.e. the register value at the edge.
  capture_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_data (cnt_q),
    .pop       (cap_ready),
    .head      (cap_data),
    .valid     (cap_valid),
    .full      (cap_full),
    .overflow  (cap_overflow)
  );

  assign counter  = cnt_q;
  assign tc       = tc_q;
  assign div_tick = div_tick_q;

endmodule

// File: tb/tb_mod_counter_capture.sv
// Randomised and directed checks of mod_counter_capture against a queue-based reference.
module tb_mod_counter_capture;

  localparam int unsigned W    = 4;
  localparam int unsigned MOD  = 10;
  localparam int unsigned DEP  = 4;
  localparam int unsigned DV   = 3;
  localparam int unsigned MOD2 = 16;
  localparam int unsigned DV2  = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         en, up_dn, load, save, cap_ready;
  logic [W-1:0] load_val;
  logic [W-1:0] counter, cap_data;
  logic         tc, cap_valid, cap_full, cap_overflow, div_tick;

  logic         save2 = 1'b0;
  logic         ready2 = 1'b0;
  logic [W-1:0] counter2, cap_data2;
  logic         tc2, cap_valid2, cap_full2, cap_overflow2, div_tick2;

  always #5 clk = ~clk;

  mod_counter_capture #(.WIDTH(W), .MODULO(MOD), .DEPTH(DEP), .DIV(DV)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .save(save), .counter(counter), .tc(tc), .cap_data(cap_data), .cap_valid(cap_valid),
    .cap_ready(cap_ready), .cap_full(cap_full), .cap_overflow(cap_overflow),
    .div_tick(div_tick)
  );

  mod_counter_capture #(.WIDTH(W), .MODULO(MOD2), .DEPTH(DEP), .DIV(DV2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .save(save2), .counter(counter2), .tc(tc2), .cap_data(cap_data2), .cap_valid(cap_valid2),
    .cap_ready(ready2), .cap_full(cap_full2), .cap_overflow(cap_overflow2),
    .div_tick(div_tick2)
  );

  int checks = 0;
  int errors = 0;

  // Reference state
  int m_cnt, m_cnt2, cycles;
  bit m_tc, m_tc2, m_ovf, m_save_prev;
  int q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nxt(input int mod, input int cnt, input bit ld, input int lv,
                             input bit e, input bit up, output bit tco);
    tco = 1'b0;
    if (ld) return (lv >= mod) ? mod - 1 : lv;
    if (!e) return cnt;
    if (up) begin
      tco = (cnt == mod - 1);
      return (cnt + 1) % mod;
    end
    tco = (cnt == 0);
    return (cnt + mod - 1) % mod;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_cnt2 = 0; m_tc = 0; m_tc2 = 0; m_ovf = 0; m_save_prev = 0;
    cycles = 0; q.delete();
  endtask

  task automatic check_all();
    chk("counter", 32'(counter), m_cnt);
    chk("tc", 32'(tc), 32'(m_tc));
    chk("cap_valid", 32'(cap_valid), 32'(q.size() > 0));
    if (q.size() > 0) chk("cap_data", 32'(cap_data), q[0]);
    chk("cap_full", 32'(cap_full), 32'(q.size() == DEP));
    chk("cap_overflow", 32'(cap_overflow), 32'(m_ovf));
    chk("div_tick", 32'(div_tick), 32'(cycles > 0 && (cycles % DV) == 0));
    chk("counter2", 32'(counter2), m_cnt2);
    chk("tc2", 32'(tc2), 32'(m_tc2));
    chk("div_tick2", 32'(div_tick2), 32'(cycles > 0));
  endtask

  // One clock edge: advance the reference with the applied inputs, then compare.
  task automatic step();
    bit push, pop, t;
    int oldc;
    @(posedge clk);
    push = save && !m_save_prev;
    pop  = (q.size() > 0) && cap_ready;
    oldc = m_cnt;
    if (push && q.size() == DEP && !pop) begin
      m_ovf = 1'b1;
    end else begin
      if (pop)  q.delete(0);
      if (push) q.push_back(oldc);
    end
    m_cnt  = nxt(MOD, m_cnt, load, int'(load_val), en, up_dn, t);
    m_tc   = t;
    m_cnt2 = nxt(MOD2, m_cnt2, load, int'(load_val), en, up_dn, t);
    m_tc2  = t;
    m_save_prev = save;
    cycles++;
    #1;
    check_all();
  endtask

  task automatic drain();
    save = 0; cap_ready = 1; en = 0; load = 0;
    for (int i = 0; i < int'(DEP) + 1; i++) step();
    cap_ready = 0;
  endtask

  int first_val;

  initial begin
    rst = 1; en = 0; up_dn = 1; load = 0; load_val = '0; save = 0; cap_ready = 0;
    model_reset();
    #12;
    chk("rst_counter", 32'(counter), 0);
    chk("rst_tc", 32'(tc), 0);
    chk("rst_valid", 32'(cap_valid), 0);
    chk("rst_full", 32'(cap_full), 0);
    chk("rst_ovf", 32'(cap_overflow), 0);
    chk("rst_div_tick", 32'(div_tick), 0);
    @(posedge clk); #1;
    rst = 0;
    model_reset();

    // Count up through the wrap, then one down step from 0.
    en = 1; up_dn = 1;
    for (int i = 0; i < int'(MOD); i++) step();
    chk("wrap_up_cnt", 32'(counter), 0);
    chk("wrap_up_tc", 32'(tc), 1);
    step();
    chk("post_wrap_tc", 32'(tc), 0);
    load = 1; load_val = 4'd0; step(); load = 0;
    up_dn = 0; step();
    chk("wrap_dn_cnt", 32'(counter), MOD - 1);
    chk("wrap_dn_tc", 32'(tc), 1);

    // Load priority and clamp; loading a wrap value never pulses tc.
    up_dn = 1; load = 1; load_val = 4'd5; step();
    chk("load5", 32'(counter), 5);
    chk("load5_tc", 32'(tc), 0);
    load_val = 4'd12; step();
    chk("load12", 32'(counter), MOD - 1);
    load_val = 4'd0; step();
    chk("load_wrapval_tc", 32'(tc), 0);
    load = 0;

    // Capture ordering with consumer stalled.
    en = 1; up_dn = 1;
    for (int i = 0; i < 12; i++) begin
      save = (m_cnt == 3 || m_cnt == 6 || m_cnt == 9);
      step();
    end
    save = 0; en = 0; step();
    chk("cap_head3", 32'(cap_data), 3);
    cap_ready = 1; step();
    chk("cap_head6", 32'(cap_data), 6);
    step();
    chk("cap_head9", 32'(cap_data), 9);
    step();
    chk("cap_empty", 32'(cap_valid), 0);
    cap_ready = 0;

    // Held-high save pushes once.
    en = 1; save = 1;
    for (int i = 0; i < 5; i++) step();
    save = 0; step();
    chk("held_save_one", 32'(q.size()), 1);
    drain();

    // Overflow: five edges into a four-deep FIFO.
    en = 1; first_val = m_cnt;
    for (int i = 0; i < 5; i++) begin
      save = 1; step();
      if (i == 3) chk("full_after4", 32'(cap_full), 1);
      save = 0; step();
    end
    chk("ovf_set", 32'(cap_overflow), 1);
    chk("ovf_head", 32'(cap_data), first_val);
    save = 1; cap_ready = 1; step();
    chk("push_pop_full", 32'(cap_full), 1);
    save = 0; cap_ready = 0; step();
    chk("ovf_sticky", 32'(cap_overflow), 1);
    drain();

    // Asynchronous reset mid-operation with two entries queued at count 7.
    en = 0;
    save = 1; step(); save = 0; step();
    save = 1; step(); save = 0;
    load = 1; load_val = 4'd7; step(); load = 0;
    chk("pre_rst_cnt", 32'(counter), 7);
    chk("pre_rst_occ", 32'(q.size()), 2);
    #2 rst = 1;
    #1;
    chk("async_counter", 32'(counter), 0);
    chk("async_valid", 32'(cap_valid), 0);
    chk("async_ovf", 32'(cap_overflow), 0);
    chk("async_tc", 32'(tc), 0);
    @(posedge clk); #1;
    rst = 0;
    model_reset();

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      en        = ($urandom_range(3, 0) != 0);
      up_dn     = 1'($urandom);
      load      = ($urandom_range(15, 0) == 0);
      load_val  = W'($urandom);
      save      = 1'($urandom);
      cap_ready = ($urandom_range(2, 0) == 0);
      step();
    end

    chk("dut2_no_capture", 32'({cap_valid2, cap_full2, cap_overflow2}), 0);
    if (cap_valid2) chk("dut2_data", 32'(cap_data2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
